// File: rtl/rs_enc.sv
// gf_pkg: field parameters for the RS datapath and a GF(2^SYMB_WIDTH) multiplier.
// Default field is GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11d).
// Shared by the encoder and the decoder-side syndrome/Chien logic.
package gf_pkg;
   localparam int SYMB_WIDTH = 8;
   localparam int T_LEN      = 2;
   localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11d;

   // Shift-and-add multiply: the running multiplicand is reduced by the
   // primitive polynomial every time it overflows the symbol width.
   function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                     input logic [SYMB_WIDTH-1:0] b);
      logic [SYMB_WIDTH-1:0] p;
      logic [SYMB_WIDTH-1:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < SYMB_WIDTH; i++) begin
         if (b[i]) p = p ^ aa;
         if (aa[SYMB_WIDTH-1]) aa = (aa << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0];
         else                  aa = aa << 1;
      end
      return p;
   endfunction
endpackage

// rs_enc: systematic streaming Reed-Solomon encoder, message passed through then NPAR parity symbols.
// Latency: 1 cycle from input accept to m_tdata; one symbol per cycle when m_tready is held high.
// Backpressure: output register holds while m_tvalid && !m_tready; s_tready low then and during parity.
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   s_tvalid/s_tready/s_tdata/s_tlast   message symbol stream, highest-degree coefficient first
//   m_tvalid/m_tready/m_tdata/m_tlast   codeword stream, m_tlast on the final parity symbol
//   len_err                       one-cycle pulse when a message exceeds KMAX symbols
module rs_enc
   import gf_pkg::*;
#(
   parameter int FCR = 0
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [SYMB_WIDTH-1:0] s_tdata,
   input  logic                  s_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [SYMB_WIDTH-1:0] m_tdata,
   output logic                  m_tlast,
   output logic                  len_err
);

   localparam int NPAR = 2 * T_LEN;
   localparam int KMAX = (2 ** SYMB_WIDTH) - 1 - NPAR;
   localparam int MCW  = $clog2(KMAX + 2);
   localparam int PCW  = (NPAR > 1) ? $clog2(NPAR) : 1;

   typedef logic [SYMB_WIDTH-1:0] sym_t;
   typedef logic [NPAR-1:0][SYMB_WIDTH-1:0] poly_t;
   typedef enum logic {MSG, PAR} state_t;

   // Expand g(x) = prod (x + alpha^(FCR+i)) one root at a time.
   // c[j] holds the coefficient of x^j; the monic x^NPAR term is dropped.
   function automatic poly_t gen_poly();
      logic [NPAR:0][SYMB_WIDTH-1:0] c;
      sym_t  root;
      poly_t r;
      c    = '0;
      c[0] = sym_t'(1);
      root = sym_t'(1);
      for (int k = 0; k < FCR; k++) root = gf_mult(root, sym_t'(2));
      for (int i = 0; i < NPAR; i++) begin
         for (int j = NPAR; j > 0; j--) c[j] = c[j-1] ^ gf_mult(c[j], root);
         c[0] = gf_mult(c[0], root);
         root = gf_mult(root, sym_t'(2));
      end
      for (int j = 0; j < NPAR; j++) r[j] = c[j];
      return r;
   endfunction

   localparam poly_t G = gen_poly();

   state_t           state;
   poly_t            par;
   poly_t            par_fb;
   logic [MCW-1:0]   msg_cnt;
   logic [PCW-1:0]   pcnt;
   logic             ld;
   logic             accept;
   logic             par_last;
   sym_t             fb;

   assign ld       = !m_tvalid || m_tready;
   assign s_tready = (state == MSG) && ld;
   assign accept   = s_tvalid && s_tready;
   assign fb       = s_tdata ^ par[NPAR-1];
   assign par_last = (pcnt == PCW'(NPAR - 1));

   // Division LFSR: highest remainder term plus the new symbol is the feedback.
   always_comb begin
      par_fb    = '0;
      par_fb[0] = gf_mult(fb, G[0]);
      for (int i = 1; i < NPAR; i++) par_fb[i] = par[i-1] ^ gf_mult(fb, G[i]);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= MSG;
         par      <= '0;
         msg_cnt  <= '0;
         pcnt     <= '0;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
         len_err  <= 1'b0;
      end else begin
         len_err <= 1'b0;
         if (state == MSG) begin
            if (accept) begin
               par      <= par_fb;
               m_tvalid <= 1'b1;
               m_tdata  <= s_tdata;
               m_tlast  <= 1'b0;
               // Saturate one past KMAX so the error pulse fires exactly once.
               if (msg_cnt != MCW'(KMAX + 1)) msg_cnt <= msg_cnt + MCW'(1);
               if (msg_cnt == MCW'(KMAX))     len_err <= 1'b1;
               if (s_tlast) begin
                  state <= PAR;
                  pcnt  <= '0;
               end
            end else if (m_tready) begin
               m_tvalid <= 1'b0;
            end
         end else begin
            if (ld) begin
               m_tvalid <= 1'b1;
               m_tdata  <= par[NPAR-1];
               m_tlast  <= par_last;
               // Shifting zeros in leaves par cleared for the next codeword.
               par      <= {par[NPAR-2:0], sym_t'(0)};
               pcnt     <= pcnt + PCW'(1);
               if (par_last) begin
                  state   <= MSG;
                  msg_cnt <= '0;
               end
            end
         end
      end
   end

endmodule
